// File: rtl/div_result_checker.sv
// Reverse-direction cross-check for the divider: rebuilds Q*B + R with a shift-add
// multiplier and compares it against the original dividend.
module div_result_checker #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   quotient,
  input  logic [WIDTH-1:0]   remainder,
  input  logic [WIDTH-1:0]   divisor,
  input  logic [WIDTH-1:0]   expected_a,
  output logic [2*WIDTH-1:0] reconstructed,
  output logic               match,
  output logic               rem_err,
  output logic               overflow,
  output logic               busy,
  output logic               finish
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StMul, StAdd, StDone} state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;  // remaining quotient bits, LSB consumed each MUL edge
  logic [PW-1:0]    mcand_q, mcand_d;    // divisor shifted left by the current bit index
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]    recon_q, recon_d;
  logic             match_q, match_d;
  logic             rem_err_q, rem_err_d;
  logic             ovf_q, ovf_d;

  logic [PW-1:0] sum;
  logic          rem_err_c;
  logic          ovf_c;

  always_comb begin
    state_d   = state_q;
    mplier_d  = mplier_q;
    mcand_d   = mcand_q;
    rem_d     = rem_q;
    div_d     = div_q;
    exp_d     = exp_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    recon_d   = recon_q;
    match_d   = match_q;
    rem_err_d = rem_err_q;
    ovf_d     = ovf_q;

    sum       = acc_q + {{WIDTH{1'b0}}, rem_q};
    rem_err_c = (rem_q >= div_q);
    ovf_c     = |sum[PW-1:WIDTH];

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mplier_d = quotient;
          mcand_d  = {{WIDTH{1'b0}}, divisor};
          rem_d    = remainder;
          div_d    = divisor;
          exp_d    = expected_a;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StMul;
        end
      end
      StMul: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mplier_d = mplier_q >> 1;
        mcand_d  = mcand_q << 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = StAdd;
        end
      end
      StAdd: begin
        acc_d     = sum;
        recon_d   = sum;
        rem_err_d = rem_err_c;
        ovf_d     = ovf_c;
        match_d   = (sum == {{WIDTH{1'b0}}, exp_q}) && !rem_err_c && !ovf_c;
        state_d   = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      mplier_q  <= '0;
      mcand_q   <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      exp_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      recon_q   <= '0;
      match_q   <= 1'b0;
      rem_err_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mplier_q  <= mplier_d;
      mcand_q   <= mcand_d;
      rem_q     <= rem_d;
      div_q     <= div_d;
      exp_q     <= exp_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      recon_q   <= recon_d;
      match_q   <= match_d;
      rem_err_q <= rem_err_d;
      ovf_q     <= ovf_d;
    end
  end

  assign reconstructed = recon_q;
  assign match         = match_q;
  assign rem_err       = rem_err_q;
  assign overflow      = ovf_q;
  assign busy          = (state_q != StIdle);
  assign finish        = (state_q == StDone);

endmodule

// File: tb/tb_div_result_checker.sv
// Bench for div_result_checker: directed table, multi-cycle corner sequences and
// random operands checked against a plain-arithmetic model of Q*B + R.
module tb_div_result_checker;

  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   quotient, remainder, divisor, expected_a;
  logic [2*W-1:0] reconstructed;
  logic           match, rem_err, overflow, busy, finish;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div_result_checker #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .quotient     (quotient),
    .remainder    (remainder),
    .divisor      (divisor),
    .expected_a   (expected_a),
    .reconstructed(reconstructed),
    .match        (match),
    .rem_err      (rem_err),
    .overflow     (overflow),
    .busy         (busy),
    .finish       (finish)
  );

  typedef struct {
    logic [31:0] q, r, b, a;
    logic [63:0] rec;
    logic        m, re, ov;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] q, r, b, a, input logic [63:0] rec,
                              input logic m, re, ov);
    vec_t v;
    v.q = q; v.r = r; v.b = b; v.a = a; v.rec = rec; v.m = m; v.re = re; v.ov = ov;
    return v;
  endfunction

  // Reference: full-precision product plus remainder, then the three flag rules.
  function automatic vec_t model(input logic [31:0] q, r, b, a);
    vec_t v;
    v.q = q; v.r = r; v.b = b; v.a = a;
    v.rec = 64'(q) * 64'(b) + 64'(r);
    v.re  = (r >= b);
    v.ov  = (v.rec[63:32] != 32'd0);
    v.m   = (v.rec == 64'(a)) && !v.re && !v.ov;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    quotient = v.q; remainder = v.r; divisor = v.b; expected_a = v.a;
  endtask

  task automatic scramble();
    quotient = $urandom; remainder = $urandom; divisor = $urandom; expected_a = $urandom;
  endtask

  task automatic chk_result(input string tag, input vec_t v);
    chk({tag, " rec"}, reconstructed, v.rec);
    chk({tag, " match"}, 64'(match), 64'(v.m));
    chk({tag, " rem_err"}, 64'(rem_err), 64'(v.re));
    chk({tag, " overflow"}, 64'(overflow), 64'(v.ov));
  endtask

  // Full operation; inputs are scrambled after acceptance to prove they were latched.
  task automatic run_op(input vec_t v, input string tag);
    int cyc;
    @(negedge clk);
    drive(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble();
    cyc = 1;
    chk({tag, " busy"}, 64'(busy), 64'd1);
    while (!finish && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " latency"}, 64'(cyc), 64'(W + 2));
    chk_result(tag, v);
    @(negedge clk);
    chk({tag, " finish pulse"}, 64'(finish), 64'd0);
    chk({tag, " idle"}, 64'(busy), 64'd0);
  endtask

  vec_t tbl[6];
  vec_t t1, t2, t3, v;
  int   n, first, second, seen;

  initial begin
    tbl[0] = mk(32'd126, 32'd5, 32'd10, 32'd1265, 64'd1265, 1'b1, 1'b0, 1'b0);
    tbl[1] = mk(32'd40, 32'd7, 32'd13, 32'd527, 64'd527, 1'b1, 1'b0, 1'b0);
    tbl[2] = mk(32'd126, 32'd5, 32'd10, 32'd1266, 64'd1265, 1'b0, 1'b0, 1'b0);
    tbl[3] = mk(32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'd1, 64'hFFFF_FFFE_0000_0001,
                1'b0, 1'b0, 1'b1);
    tbl[4] = mk(32'd1, 32'd7, 32'd5, 32'd12, 64'd12, 1'b0, 1'b1, 1'b0);
    tbl[5] = mk(32'd9, 32'd3, 32'd0, 32'd3, 64'd3, 1'b0, 1'b1, 1'b0);
    t1 = tbl[0]; t2 = tbl[1]; t3 = tbl[2];

    reset = 1'b1; start = 1'b0;
    quotient = '0; remainder = '0; divisor = '0; expected_a = '0;
    repeat (3) @(negedge clk);
    chk("reset rec", reconstructed, 64'd0);
    chk("reset match", 64'(match), 64'd0);
    chk("reset rem_err", 64'(rem_err), 64'd0);
    chk("reset overflow", 64'(overflow), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset finish", 64'(finish), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_op(tbl[i], $sformatf("T%0d", i));

    // Starts during MUL and during DONE are both dropped.
    @(negedge clk);
    drive(t1); start = 1'b1;
    @(negedge clk);
    start = 1'b0; n = 1;
    while (!finish && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 10) begin drive(t3); start = 1'b1; end
      else start = 1'b0;
    end
    chk("ign latency", 64'(n), 64'(W + 2));
    drive(t3); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy) seen++;
    end
    chk("ign done start", 64'(seen), 64'd0);
    chk_result("ign", t1);

    // Mid-operation reset: previous results held until reset, then all cleared.
    @(negedge clk);
    drive(t1); start = 1'b1;
    @(negedge clk);
    start = 1'b0; n = 1;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (n == 10) begin
        chk("hold rec", reconstructed, 64'd1265);
        chk("hold busy", 64'(busy), 64'd1);
        drive(t3); start = 1'b1;
      end else start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst rec", reconstructed, 64'd0);
    chk("rst match", 64'(match), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst finish", 64'(finish), 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (finish || busy) seen++;
    end
    chk("rst no finish", 64'(seen), 64'd0);
    run_op(t2, "post-rst T2");

    // Start held high: back-to-back checks every W+3 cycles.
    @(negedge clk);
    drive(t2); start = 1'b1;
    n = 0; first = 0; second = 0;
    while (second == 0 && n < 200) begin
      @(negedge clk);
      n++;
      if (finish) begin
        if (first == 0) first = n;
        else second = n;
      end
    end
    start = 1'b0;
    chk("b2b first", 64'(first), 64'(W + 2));
    chk("b2b spacing", 64'(second - first), 64'(W + 3));
    chk_result("b2b", t2);
    @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] q, b, r, a;
      if ($urandom_range(0, 3) == 0) begin
        q = $urandom; b = $urandom;
      end else begin
        q = $urandom_range(0, 65535); b = $urandom_range(0, 65535);
      end
      if (b == 0) r = $urandom_range(0, 10);
      else if ($urandom_range(0, 3) == 0) r = $urandom;
      else r = $urandom % b;
      a = ($urandom_range(0, 3) == 0) ? $urandom : q * b + r;
      v = model(q, r, b, a);
      run_op(v, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
